apb_exe_ctrl: RTL and testbench

- APB3 slave front-end for the execution unit.
- Software writes operands and an opcode over APB, then sets START. The block then issues a one-cycle start pulse to the downstream exe unit and waits for its valid strobe.
- On valid it captures the 2N-bit result in its RESULT register and reports completion through STATUS and irq.
- It is the stage directly upstream of the exe unit's operand/result registers and drives their inputs.

---
 rtl/apb_exe_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_apb_exe_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_exe_ctrl.sv
// APB3 register front-end for the execution unit: operand/opcode registers,
// START handshake towards the exe unit, result capture, STATUS and level irq.
module apb_exe_ctrl #(
  parameter int N   = 8,
  parameter int DW  = 32,
  parameter int AW  = 8,
  parameter int OPW = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_psel,
  input  logic             i_penable,
  input  logic             i_pwrite,
  input  logic [AW-1:0]    i_paddr,
  input  logic [DW-1:0]    i_pwdata,
  output logic [DW-1:0]    o_prdata,
  output logic             o_pready,
  output logic             o_pslverr,
  output logic [N-1:0]     o_exe_a,
  output logic [N-1:0]     o_exe_b,
  output logic [OPW-1:0]   o_exe_op,
  output logic             o_exe_start,
  input  logic [2*N-1:0]   i_exe_result,
  input  logic             i_exe_valid,
  output logic             o_irq
);

  typedef enum logic [1:0] {
    APB_IDLE = 2'd0,
    APB_WAIT = 2'd1,
    APB_ACK  = 2'd2
  } apb_state_t;

  typedef enum logic [1:0] {
    EXE_IDLE  = 2'd0,
    EXE_START = 2'd1,
    EXE_RUN   = 2'd2
  } exe_state_t;

  apb_state_t         r_apb_state, w_apb_next;
  exe_state_t         r_exe_state, w_exe_next;

  logic [N-1:0]       r_opa;
  logic [N-1:0]       r_opb;
  logic [OPW-1:0]     r_opcode;
  logic [2*N-1:0]     r_result;
  logic               r_done;
  logic               r_err;

  logic               w_access;
  logic               w_busy;
  logic               w_sel_opa, w_sel_opb, w_sel_ctrl, w_sel_status, w_sel_result;
  logic               w_mapped;
  logic               w_wr_rw;
  logic               w_busy_viol;
  logic               w_err_resp;
  logic               w_wr_ok;
  logic               w_start_req;
  logic               w_status_rd;
  logic               w_result_cap;
  logic [DW-1:0]      w_rdata;
  logic               w_unused;

  assign w_access     = (r_apb_state == APB_ACK);
  assign w_busy       = (r_exe_state != EXE_IDLE);
  assign w_unused     = ^{i_pwdata, i_paddr[1:0]};

  // Word decode; any set bit above the five mapped words makes the offset unmapped.
  always_comb begin
    w_sel_opa    = 1'b0;
    w_sel_opb    = 1'b0;
    w_sel_ctrl   = 1'b0;
    w_sel_status = 1'b0;
    w_sel_result = 1'b0;
    if (~|i_paddr[AW-1:5]) begin
      case (i_paddr[4:2])
        3'd0:    w_sel_opa    = 1'b1;
        3'd1:    w_sel_opb    = 1'b1;
        3'd2:    w_sel_ctrl   = 1'b1;
        3'd3:    w_sel_status = 1'b1;
        3'd4:    w_sel_result = 1'b1;
        default: w_sel_opa    = 1'b0;
      endcase
    end else begin
      w_sel_opa = 1'b0;
    end
  end

  assign w_mapped     = w_sel_opa | w_sel_opb | w_sel_ctrl | w_sel_status | w_sel_result;
  assign w_wr_rw      = i_pwrite & (w_sel_opa | w_sel_opb | w_sel_ctrl);
  assign w_busy_viol  = w_access & w_wr_rw & w_busy;
  assign w_err_resp   = ~w_mapped | (i_pwrite & (w_sel_status | w_sel_result)) | (w_wr_rw & w_busy);
  assign w_wr_ok      = w_access & i_pwrite & ~w_busy;
  assign w_start_req  = w_wr_ok & w_sel_ctrl & i_pwdata[31];
  assign w_status_rd  = w_access & ~i_pwrite & w_sel_status;
  assign w_result_cap = (r_exe_state == EXE_RUN) & i_exe_valid;

  // Read-data mux; only drives the bus during the ACK cycle of a read.
  always_comb begin
    w_rdata = {DW{1'b0}};
    if (w_access & ~i_pwrite) begin
      if (w_sel_opa) begin
        w_rdata[N-1:0] = r_opa;
      end else if (w_sel_opb) begin
        w_rdata[N-1:0] = r_opb;
      end else if (w_sel_ctrl) begin
        w_rdata[OPW-1:0] = r_opcode;
      end else if (w_sel_status) begin
        w_rdata[2:0] = {r_err, r_done, w_busy};
      end else if (w_sel_result) begin
        w_rdata[2*N-1:0] = r_result;
      end else begin
        w_rdata = {DW{1'b0}};
      end
    end else begin
      w_rdata = {DW{1'b0}};
    end
  end

  assign o_prdata  = w_rdata;
  assign o_pready  = w_access;
  assign o_pslverr = w_access & w_err_resp;

  // APB handshake next state: one wait state before every ACK.
  always_comb begin
    w_apb_next = r_apb_state;
    case (r_apb_state)
      APB_IDLE: begin
        if (i_psel & i_penable) begin
          w_apb_next = APB_WAIT;
        end else begin
          w_apb_next = APB_IDLE;
        end
      end
      APB_WAIT: w_apb_next = APB_ACK;
      APB_ACK:  w_apb_next = APB_IDLE;
      default:  w_apb_next = APB_IDLE;
    endcase
  end

  // Exe sequencing next state; exe_valid only matters while running.
  always_comb begin
    w_exe_next = r_exe_state;
    case (r_exe_state)
      EXE_IDLE: begin
        if (w_start_req) begin
          w_exe_next = EXE_START;
        end else begin
          w_exe_next = EXE_IDLE;
        end
      end
      EXE_START: w_exe_next = EXE_RUN;
      EXE_RUN: begin
        if (i_exe_valid) begin
          w_exe_next = EXE_IDLE;
        end else begin
          w_exe_next = EXE_RUN;
        end
      end
      default: w_exe_next = EXE_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_apb_state <= APB_IDLE;
      r_exe_state <= EXE_IDLE;
    end else begin
      r_apb_state <= w_apb_next;
      r_exe_state <= w_exe_next;
    end
  end

  // Software-visible registers; done set takes priority over the STATUS-read clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_opa    <= {N{1'b0}};
      r_opb    <= {N{1'b0}};
      r_opcode <= {OPW{1'b0}};
      r_result <= {(2*N){1'b0}};
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_wr_ok & w_sel_opa) begin
        r_opa <= i_pwdata[N-1:0];
      end
      if (w_wr_ok & w_sel_opb) begin
        r_opb <= i_pwdata[N-1:0];
      end
      if (w_wr_ok & w_sel_ctrl) begin
        r_opcode <= i_pwdata[OPW-1:0];
      end
      if (w_result_cap) begin
        r_result <= i_exe_result;
      end
      if (w_result_cap) begin
        r_done <= 1'b1;
      end else if (w_status_rd) begin
        r_done <= 1'b0;
      end
      if (w_busy_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_exe_a     = r_opa;
  assign o_exe_b     = r_opb;
  assign o_exe_op    = r_opcode;
  assign o_exe_start = (r_exe_state == EXE_START);
  assign o_irq       = r_done;

endmodule

// File: tb/tb_apb_exe_ctrl.sv
// Directed bench for apb_exe_ctrl: a register-access vector table plus
// hand-written sequences for start/valid handshakes, busy protection and reset.
module tb_apb_exe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  exe_a, exe_b;
  logic [3:0]  exe_op;
  logic        exe_start;
  logic [15:0] exe_result;
  logic        exe_valid;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  apb_exe_ctrl #(.N(8), .DW(32), .AW(8), .OPW(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_psel(psel), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
    .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
    .o_exe_a(exe_a), .o_exe_b(exe_b), .o_exe_op(exe_op), .o_exe_start(exe_start),
    .i_exe_result(exe_result), .i_exe_valid(exe_valid), .o_irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One APB transfer; optionally pulses exe_valid so it lands on the commit edge.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic pulse_valid, input logic [15:0] res,
                     output logic [31:0] rdata, output logic slverr);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    chk("pready_setup", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    chk("pready_access", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    chk("pready_wait", {31'd0, pready}, 32'd0);
    chk("prdata_wait", prdata, 32'd0);
    chk("pslverr_wait", {31'd0, pslverr}, 32'd0);
    @(posedge clk); #1;
    chk("pready_ack", {31'd0, pready}, 32'd1);
    rdata  = prdata;
    slverr = pslverr;
    if (pulse_valid) begin
      exe_valid = 1'b1; exe_result = res;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; exe_valid = 1'b0;
    chk("pready_after", {31'd0, pready}, 32'd0);
  endtask

  task automatic rd(input string name, input logic [7:0] addr, input logic [31:0] exp, input logic exp_err);
    logic [31:0] d;
    logic        e;
    apb(1'b0, addr, 32'd0, 1'b0, 16'd0, d, e);
    chk({name, "_rdata"}, d, exp);
    chk({name, "_slverr"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic wr(input string name, input logic [7:0] addr, input logic [31:0] data, input logic exp_err);
    logic [31:0] d;
    logic        e;
    apb(1'b1, addr, data, 1'b0, 16'd0, d, e);
    chk({name, "_slverr"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic pulse_valid(input logic [15:0] res);
    @(posedge clk); #1;
    exe_valid = 1'b1; exe_result = res;
    @(posedge clk); #1;
    exe_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;

    vecs[0]  = '{1'b0, 8'h00, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 8'h10, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 8'h00, 32'h0000_00AA, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 8'h04, 32'hFFFF_FF55, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 32'h0000_0000, 32'h0000_00AA, 1'b0};
    vecs[8]  = '{1'b0, 8'h04, 32'h0000_0000, 32'h0000_0055, 1'b0};
    vecs[9]  = '{1'b0, 8'h07, 32'h0000_0000, 32'h0000_0055, 1'b0};
    vecs[10] = '{1'b1, 8'h08, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 8'h08, 32'h0000_0000, 32'h0000_0005, 1'b0};
    vecs[12] = '{1'b0, 8'h0C, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 8'h20, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, 8'h10, 32'h0000_DEAD, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 8'h10, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b1, 8'h0C, 32'h0000_0007, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b0, 8'h0C, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[18] = '{1'b0, 8'h14, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[19] = '{1'b1, 8'h80, 32'h0000_0033, 32'h0000_0000, 1'b1};

    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 32'd0; exe_result = 16'd0; exe_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_exe_start", {31'd0, exe_start}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 16'd0, d, e);
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_slverr", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
    end
    chk("exe_a", {24'd0, exe_a}, 32'h0000_00AA);
    chk("exe_b", {24'd0, exe_b}, 32'h0000_0055);
    chk("exe_op_nostart", {28'd0, exe_op}, 32'd5);
    chk("no_start_pulse", {31'd0, exe_start}, 32'd0);

    // exe_valid while idle must be ignored
    pulse_valid(16'hBEEF);
    chk("idle_valid_irq", {31'd0, irq}, 32'd0);
    rd("idle_valid_result", 8'h10, 32'd0, 1'b0);

    // first operation: one-cycle start pulse right after the CTRL commit
    wr("start1", 8'h08, 32'h8000_0003, 1'b0);
    chk("start1_pulse", {31'd0, exe_start}, 32'd1);
    chk("start1_op", {28'd0, exe_op}, 32'd3);
    @(posedge clk); #1;
    chk("start1_pulse_end", {31'd0, exe_start}, 32'd0);
    rd("busy_status", 8'h0C, 32'h0000_0001, 1'b0);
    chk("busy_no_pulse", {31'd0, exe_start}, 32'd0);
    pulse_valid(16'h00FF);
    chk("done_irq", {31'd0, irq}, 32'd1);
    rd("result1", 8'h10, 32'h0000_00FF, 1'b0);
    rd("done_status", 8'h0C, 32'h0000_0002, 1'b0);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd("status_after_clr", 8'h0C, 32'h0000_0000, 1'b0);

    // second operation: busy protection
    wr("start2", 8'h08, 32'h8000_0002, 1'b0);
    chk("start2_pulse", {31'd0, exe_start}, 32'd1);
    wr("busy_wr_opa", 8'h00, 32'h0000_0011, 1'b1);
    rd("busy_rd_opa", 8'h00, 32'h0000_00AA, 1'b0);
    chk("busy_exe_a", {24'd0, exe_a}, 32'h0000_00AA);
    rd("err_status", 8'h0C, 32'h0000_0005, 1'b0);
    wr("busy_restart", 8'h08, 32'h8000_0007, 1'b1);
    chk("busy_restart_op", {28'd0, exe_op}, 32'd2);
    chk("busy_restart_pulse", {31'd0, exe_start}, 32'd0);
    rd("busy_rd_ctrl", 8'h08, 32'h0000_0002, 1'b0);
    pulse_valid(16'hABCD);
    rd("result2", 8'h10, 32'h0000_ABCD, 1'b0);
    rd("done_err_status", 8'h0C, 32'h0000_0006, 1'b0);
    chk("irq_cleared2", {31'd0, irq}, 32'd0);

    // done set and STATUS-read clear on the same edge: set wins
    wr("start3", 8'h08, 32'h8000_0004, 1'b0);
    apb(1'b0, 8'h0C, 32'd0, 1'b1, 16'h5A5A, d, e);
    chk("race_status", d, 32'h0000_0005);
    chk("race_slverr", {31'd0, e}, 32'd0);
    chk("race_irq", {31'd0, irq}, 32'd1);
    rd("race_result", 8'h10, 32'h0000_5A5A, 1'b0);
    rd("race_status2", 8'h0C, 32'h0000_0006, 1'b0);
    chk("race_irq_clr", {31'd0, irq}, 32'd0);

    // reset while running aborts; a late exe_valid is ignored
    wr("start4", 8'h08, 32'h8000_0001, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_exe_start", {31'd0, exe_start}, 32'd0);
    chk("midrst_exe_a", {24'd0, exe_a}, 32'd0);
    reset = 1'b0;
    pulse_valid(16'h1234);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    rd("midrst_status", 8'h0C, 32'h0000_0000, 1'b0);
    rd("midrst_result", 8'h10, 32'h0000_0000, 1'b0);
    rd("midrst_ctrl", 8'h08, 32'h0000_0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
